// File: rtl/instruction_prefetch_unit.sv
// Fetch stage: owns the fetch PC, issues in-order word reads and buffers responses for IF/ID.
// Optional PREFETCH_BYPASS_EN forwards a response straight to the outputs when the FIFO is empty.
module instruction_prefetch_unit #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 20,
  parameter int DEPTH    = 4,
  parameter int MAX_OUT  = 3,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_enable,
  input  logic [ADDR_W-1:0] jump_address,
  input  logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_address,
  input  logic              mem_grant,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr, rd_nxt;
  logic [CW-1:0]     count, count_nxt;
  logic [2:0]        pending, discard;
  logic [ADDR_W-1:0] fetch_pc, resp_pc;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] head_pc;
  logic              fifo_empty, resp_accept, resp_drop, issue, push, pop, bypass_take;

  always_comb begin
    fifo_empty  = (count == '0);
    resp_accept = mem_data_valid && (discard == 3'd0) && (pending != 3'd0);
    resp_drop   = mem_data_valid && (discard != 3'd0);
    // Credit covers both FIFO space (entries + reads that will land) and bus occupancy.
    mem_req     = rst_n && !jump_enable
                  && ((32'(count) + 32'(pending)) < 32'(DEPTH))
                  && ((32'(pending) + 32'(discard)) < 32'(MAX_OUT));
    issue       = mem_req && mem_grant;
`ifdef PREFETCH_BYPASS_EN
    bypass_take = fifo_empty && resp_accept && !stall && !jump_enable;
    instr_valid = !fifo_empty || resp_accept;
    instr_out   = (fifo_empty && resp_accept) ? mem_data : head_data;
    instr_pc    = (fifo_empty && resp_accept) ? resp_pc  : head_pc;
`else
    bypass_take = 1'b0;
    instr_valid = !fifo_empty;
    instr_out   = head_data;
    instr_pc    = head_pc;
`endif
    push        = resp_accept && !bypass_take && !jump_enable;
    pop         = !fifo_empty && !stall && !jump_enable;
    rd_nxt      = rd_ptr + PW'(pop);
    count_nxt   = count + CW'(push) - CW'(pop);
    mem_address = fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_data;
      fifo_pc[wr_ptr]   <= resp_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      resp_pc   <= RESET_PC;
      pending   <= '0;
      discard   <= '0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      head_data <= '0;
      head_pc   <= '0;
    end else if (jump_enable) begin
      // Every read not yet returned becomes a discard; nothing issues in this cycle.
      fetch_pc <= jump_address;
      resp_pc  <= jump_address;
      discard  <= discard + pending - 3'(resp_accept) - 3'(resp_drop);
      pending  <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (issue)       fetch_pc <= fetch_pc + 1'b1;
      if (resp_accept) resp_pc  <= resp_pc + 1'b1;
      pending <= pending + 3'(issue) - 3'(resp_accept);
      discard <= discard - 3'(resp_drop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_nxt;
      count  <= count_nxt;
      // Head registers track the next head; they hold their value once the FIFO drains.
      if (count_nxt != '0) begin
        if (push && (rd_nxt == wr_ptr)) begin
          head_data <= mem_data;
          head_pc   <= resp_pc;
        end else begin
          head_data <= fifo_data[rd_nxt];
          head_pc   <= fifo_pc[rd_nxt];
        end
      end else if (bypass_take) begin
        head_data <= mem_data;
        head_pc   <= resp_pc;
      end
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Bench for instruction_prefetch_unit: in-order memory model plus an expected-stream model
// (consecutive PCs from reset/jump target, data = PC + offset).
module tb_instruction_prefetch_unit;
  localparam int AW = 20;
  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          jump_enable, stall, mem_grant, mem_data_valid;
  logic [AW-1:0] jump_address, mem_address, instr_pc;
  logic [DW-1:0] mem_data, instr_out;
  logic          mem_req, instr_valid;

  instruction_prefetch_unit dut (
    .clk(clk), .rst_n(rst_n), .jump_enable(jump_enable), .jump_address(jump_address),
    .stall(stall), .mem_req(mem_req), .mem_address(mem_address), .mem_grant(mem_grant),
    .mem_data_valid(mem_data_valid), .mem_data(mem_data), .instr_valid(instr_valid),
    .instr_out(instr_out), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; int due; } req_t;
  req_t          mq[$];
  logic [AW-1:0] m_fetch, exp_pc;
  logic [DW-1:0] off;
  int            edges, lat_min, lat_max, checks, errors, first_valid, rel_edge;
  logic          post_jump, last_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; jump_enable = 0; stall = 0; mem_grant = 0; mem_data_valid = 0;
    jump_address = '0; mem_data = '0;
    #1;
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr_out", instr_out, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_address", mem_address, 0);
    mq.delete();
    m_fetch = '0; exp_pc = '0; post_jump = 0; first_valid = -1;
    repeat (2) begin @(posedge clk); edges++; end
    #2 rst_n = 1'b1;
    rel_edge = edges;
  endtask

  task automatic cycle(input logic st, input logic jmp, input logic [AW-1:0] ja,
                       input logic gr, input logic stray);
    logic          consumed, req_s, dv;
    logic [DW-1:0] ed;
    @(negedge clk);
    stall = st; jump_enable = jmp; jump_address = ja; mem_grant = gr;
    dv = 1'b0;
    if (mq.size() > 0 && mq[0].due <= edges + 1) begin
      mem_data_valid = 1'b1; mem_data = mq[0].addr + off; dv = 1'b1;
    end else if (stray && mq.size() == 0) begin
      mem_data_valid = 1'b1; mem_data = DW'($urandom);
    end else begin
      mem_data_valid = 1'b0; mem_data = DW'($urandom);
    end
    #1;
    check("mem_address", mem_address, m_fetch);
    if (jmp)       check("mem_req_in_jump", mem_req, 0);
    if (post_jump) check("valid_after_jump", instr_valid, 0);
    if (instr_valid) begin
      ed = exp_pc + off;
      check("instr_pc", instr_pc, exp_pc);
      check("instr_out", instr_out, ed);
    end
    if (instr_valid && first_valid < 0) first_valid = edges + 1 - rel_edge;
    last_valid = instr_valid;
    consumed = instr_valid && !st && !jmp;
    req_s = mem_req;
    @(posedge clk);
    edges++;
    if (dv) void'(mq.pop_front());
    if (jmp) begin
      m_fetch = ja; exp_pc = ja;
    end else begin
      if (req_s && gr) begin
        mq.push_back('{addr: m_fetch, due: edges + int'($urandom_range(lat_max, lat_min))});
        m_fetch++;
      end
      if (consumed) exp_pc++;
    end
    post_jump = jmp;
  endtask

  initial begin
    logic [AW-1:0] cap;
    checks = 0; errors = 0; edges = 0; off = 20'h10000;
    lat_min = 1; lat_max = 1;

    // 1: reset, streaming with 1-cycle memory
    do_reset();
    repeat (12) cycle(0, 0, '0, 1, 0);
`ifdef PREFETCH_BYPASS_EN
    check("first_valid_latency", first_valid, 2);
`else
    check("first_valid_latency", first_valid, 3);
`endif
    check("stream1_progress", 32'(exp_pc >= 20'd8), 1);

    // 2: mid-operation reset, then long stall fills the FIFO
    do_reset();
    repeat (10) cycle(1, 0, '0, 1, 0);
    #1;
    check("stall_mem_req", mem_req, 0);
    check("stall_mem_address", mem_address, 4);
    check("stall_valid", instr_valid, 1);
    check("stall_head_pc", instr_pc, 0);
    repeat (12) cycle(0, 0, '0, 1, 0);
    check("unstall_progress", 32'(exp_pc >= 20'd8), 1);

    // 3: 3-cycle memory, jump with three reads in flight
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && mq.size() != 3; i++) cycle(0, 0, '0, 1, 0);
    check("outstanding_at_jump", mq.size(), 3);
    cycle(0, 1, 20'h00100, 1, 0);
    repeat (20) cycle(0, 0, '0, 1, 0);
    check("jump_progress", 32'(exp_pc > 20'h00103 && exp_pc < 20'h00120), 1);

    // 4: PC wrap
    lat_min = 1; lat_max = 1;
    cycle(0, 1, 20'hFFFFE, 1, 0);
    repeat (8) cycle(0, 0, '0, 1, 0);
    check("wrap_progress", 32'(exp_pc >= 20'd2 && exp_pc < 20'h10), 1);

    // 5: grant withheld, then stray responses with nothing outstanding
    #1 cap = mem_address;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, '0, 0, 0);
      #1;
      check("nogrant_mem_req", mem_req, 1);
      check("nogrant_addr", mem_address, cap);
    end
    cycle(0, 0, '0, 0, 1);
    check("stray_valid_same", last_valid, 0);
    cycle(0, 0, '0, 0, 1);
    check("stray_valid_next", last_valid, 0);
    cycle(0, 0, '0, 0, 0);
    check("stray_valid_after", last_valid, 0);
    repeat (6) cycle(0, 0, '0, 1, 0);
    check("resume_after_stray", 32'(exp_pc != cap), 1);

`ifdef PREFETCH_BYPASS_EN
    // 6: same-cycle bypass
    do_reset();
    off = 20'h2ABBD;
    cycle(0, 1, 20'h00010, 0, 0);
    cycle(0, 0, '0, 1, 0);
    cycle(0, 0, '0, 0, 0);
    check("bypass_valid", last_valid, 1);
    cycle(0, 0, '0, 0, 0);
    check("bypass_no_store", last_valid, 0);
    cycle(1, 0, '0, 1, 0);
    cycle(1, 0, '0, 0, 0);
    check("bypass_stall_valid", last_valid, 1);
    cycle(1, 0, '0, 0, 0);
    check("bypass_stall_stored", last_valid, 1);
    check("bypass_stall_pc", exp_pc, 20'h00011);
    cycle(0, 0, '0, 0, 0);
`endif

    // randomized traffic
    do_reset();
    off = DW'($urandom);
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++)
      cycle(($urandom % 4) == 0, ($urandom % 20) == 0, AW'($urandom),
            ($urandom % 10) < 7, ($urandom % 8) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
